leg_alu_seq: RTL and testbench
==============================

// Module: leg_alu_seq
// PURPOSE
// - Parametrised LEG execute unit: single-cycle logic/add ops plus iterative MUL/MULH/DIV/MOD, one shared result port.
// - Sits between LEG decode and register-file writeback. Valid/ready handshake on both sides so the core stalls on long ops.
// - Generalises the 8-bit LEG ALU + MUL pair to any WIDTH and adds divide, modulo, flags and a registered result.
// PARAMETERS
// - WIDTH     8  operand/result width in bits; >=2.
// - CNT_W     $clog2(WIDTH)+1  iteration counter width; derived, do not override.
// PORTS
// - clk        in   1      clock; all state updates on the rising edge.
// - rst        in   1      asynchronous, active-low reset (asserted when 0).
// - in_valid   in   1      operands/opcode valid.
// - in_ready   out  1      unit can accept an op.
// - opcode     in   8      LEG opcode; only [3:0] decoded, [7:4] ignored (immediate flags).
// - in_a       in   WIDTH  operand A (dividend for DIV/MOD).
// - in_b       in   WIDTH  operand B (divisor for DIV/MOD).
// - out_valid  out  1      result/flags valid.
// - out_ready  in   1      consumer accepts result.
// - result     out  WIDTH  registered result.
// - zero       out  1      result == 0.
// - div0       out  1      DIV/MOD with in_b == 0.
// - illegal    out  1      undecoded opcode[3:0].
// BEHAVIOUR
// - Opcodes [3:0]: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOT(a), 5 XOR, 8 MUL (low WIDTH of a*b), 9 MULH (high WIDTH),
//   10 DIV (a/b), 11 MOD (a%b). All unsigned. ADD/SUB wrap modulo 2^WIDTH. Codes 6,7,12-15: illegal.
// - Reset (rst=0, async): state IDLE, in_ready=1, out_valid=0, result=0, zero=0, div0=0, illegal=0, counter=0.
// - FSM IDLE/BUSY/DONE. in_ready = (state==IDLE). Accept = in_valid & in_ready; operands/opcode latched on accept.
// - IDLE: accept of bit3=0 or illegal code -> DONE next edge (result at 1 cycle latency). Accept of bit3=1 -> BUSY.
// - BUSY: one shift-add (MUL/MULH) or restoring-subtract (DIV/MOD) step per cycle; counter WIDTH-1 down to 0;
//   after step with counter==0 -> DONE. out_valid first high WIDTH+1 cycles after accept. in_valid ignored.
// - DONE: out_valid=1; result/flags held stable until out_ready=1, then -> IDLE (no same-cycle re-accept).
// - Back-to-back max rate: one op per 2 cycles (single-cycle ops), WIDTH+2 cycles (iterative).
// - Divide by zero: no iteration skip required but result fixed: DIV -> all ones, MOD -> in_a, div0=1.
// - Illegal: result=0, illegal=1, zero=1. div0/illegal deasserted for every other op.
// - zero computed from final result for every op. Flags change only on entry to DONE.
// - rst asserted mid-BUSY/DONE: op aborted, reset values immediately; no partial result ever presented.
// - Opcode/operand changes while not accepting have no effect.
// STRUCTURE
// - leg_alu_pkg: opcode localparams (OP_ADD..OP_MOD), state enum {IDLE,BUSY,DONE}, is_iter()/is_legal() functions.
// - Sub-module leg_alu_iter: WIDTH-generic iterative datapath (2*WIDTH accumulator, shift, conditional add/sub),
//   controlled by start/step/mode from leg_alu_seq; returns hi/lo halves. Single-cycle ops and FSM stay in top.
// TESTING (WIDTH=8 unless stated)
// - Reset: rst=0 mid-MUL at cycle 3 of BUSY -> in_ready=1, out_valid=0, result=0 immediately; next op correct.
// - ADD 0xF0+0x20 -> result 0x10 one cycle after accept; SUB 0x05-0x05 -> 0x00, zero=1; hold while out_ready=0 5 cycles.
// - MUL 0xFF*0xFF -> 0x01; MULH same operands -> 0xFE; out_valid exactly 9 cycles after accept; in_ready=0 throughout.
// - DIV 100/7 -> 0x0E; MOD 100/7 -> 0x02; DIV 0x2A/0 -> 0xFF, div0=1; MOD 0x2A/0 -> 0x2A, div0=1.
// - Opcode 0x07 -> result 0, illegal=1, zero=1; opcode 0xF8 (upper bits set) with 3*4 -> MUL result 0x0C.
// - WIDTH=16 rerun: MUL 0xFFFF*0x0002 -> 0xFFFE, MULH -> 0x0001, latency 17; random ops vs reference model.

Source files
------------

// File: rtl/leg_alu_pkg.sv
// Shared opcode, FSM-state and decode helpers for the LEG execute unit.
package leg_alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_NOT  = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_MULH = 4'd9;
  localparam logic [3:0] OP_DIV  = 4'd10;
  localparam logic [3:0] OP_MOD  = 4'd11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic is_legal(input logic [3:0] op);
    return (op <= OP_XOR) || ((op >= OP_MUL) && (op <= OP_MOD));
  endfunction

  function automatic logic is_iter(input logic [3:0] op);
    return op[3] && is_legal(op);
  endfunction

endpackage

// File: rtl/leg_alu_iter.sv
// Iterative shift-add multiply / restoring divide datapath over a 2*WIDTH accumulator.
// hi/lo are the accumulator halves as they will be after the current step.
module leg_alu_iter
  import leg_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_mul;
  logic [2*WIDTH-1:0] acc_div;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   diff;
  logic               rem_ge;

  // Multiplier sits in the low half and is consumed LSB-first while the product shifts in from the top.
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b} : '0);
    acc_mul = {mul_sum, acc[WIDTH-1:1]};
  end

  // Partial remainder is one bit wider than WIDTH after the left shift; quotient bits fill from the right.
  always_comb begin
    rem     = acc[2*WIDTH-1:WIDTH-1];
    rem_ge  = (rem >= {1'b0, b});
    diff    = rem[WIDTH-1:0] - b;
    acc_div = rem_ge ? {diff, acc[WIDTH-2:0], 1'b1}
                     : {rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  assign acc_nxt = mode ? acc_div : acc_mul;
  assign hi      = acc_nxt[2*WIDTH-1:WIDTH];
  assign lo      = acc_nxt[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (start) begin
      acc <= {{WIDTH{1'b0}}, a};
    end else if (step) begin
      acc <= acc_nxt;
    end
  end

endmodule

// File: rtl/leg_alu_seq.sv
// LEG execute unit: 1-cycle logic/add ops, WIDTH+1-cycle MUL/MULH/DIV/MOD, registered result.
// Accepts only in IDLE; result and flags hold in DONE until out_ready.
module leg_alu_seq
  import leg_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       opcode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             div0,
  output logic             illegal
);

  logic [1:0]       state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       op_in;
  logic             accept;
  logic             b_zero;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] iter_res;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic             unused_opcode_hi;

  // Upper opcode bits carry immediate flags for the decoder, not for us.
  assign unused_opcode_hi = ^opcode[7:4];
  assign op_in            = opcode[3:0];
  assign in_ready         = (state == ST_IDLE);
  assign out_valid        = (state == ST_DONE);
  assign accept           = in_valid && in_ready;
  assign b_zero           = (b_q == '0);

  always_comb begin
    alu_res = '0;
    case (op_in)
      OP_ADD:  alu_res = in_a + in_b;
      OP_SUB:  alu_res = in_a - in_b;
      OP_AND:  alu_res = in_a & in_b;
      OP_OR:   alu_res = in_a | in_b;
      OP_NOT:  alu_res = ~in_a;
      OP_XOR:  alu_res = in_a ^ in_b;
      default: alu_res = '0;
    endcase
  end

  // Divide by zero returns fixed values regardless of what the iteration produced.
  always_comb begin
    iter_res = '0;
    case (op_q)
      OP_MUL:  iter_res = step_lo;
      OP_MULH: iter_res = step_hi;
      OP_DIV:  iter_res = b_zero ? '1 : step_lo;
      OP_MOD:  iter_res = b_zero ? a_q : step_hi;
      default: iter_res = '0;
    endcase
  end

  leg_alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .rst   (rst),
    .start (accept && is_iter(op_in)),
    .step  (state == ST_BUSY),
    .mode  (op_q[1]),
    .a     (in_a),
    .b     (b_q),
    .hi    (step_hi),
    .lo    (step_lo)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt     <= '0;
      result  <= '0;
      zero    <= 1'b0;
      div0    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_q <= op_in;
            a_q  <= in_a;
            b_q  <= in_b;
            if (is_iter(op_in)) begin
              state <= ST_BUSY;
              cnt   <= CNT_W'(WIDTH - 1);
            end else begin
              state   <= ST_DONE;
              result  <= alu_res;
              zero    <= (alu_res == '0);
              div0    <= 1'b0;
              illegal <= !is_legal(op_in);
            end
          end
        end
        ST_BUSY: begin
          if (cnt == '0) begin
            state   <= ST_DONE;
            result  <= iter_res;
            zero    <= (iter_res == '0);
            div0    <= op_q[1] && b_zero;
            illegal <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_leg_alu_seq.sv
// Bench for leg_alu_seq at WIDTH=8 and WIDTH=16: directed literal vectors plus a per-cycle model compare.
module tb_leg_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        sel16;
  logic [7:0]  opcode;
  logic [15:0] in_a, in_b;
  logic        out_ready;

  logic        r8, v8, z8, d8, i8;
  logic [7:0]  res8;
  logic        r16, v16, z16, d16, i16;
  logic [15:0] res16;

  logic        vr, vv, vz, vd, vi;
  logic [15:0] vres;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  leg_alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid & ~sel16), .in_ready(r8),
    .opcode(opcode), .in_a(in_a[7:0]), .in_b(in_b[7:0]),
    .out_valid(v8), .out_ready(out_ready), .result(res8),
    .zero(z8), .div0(d8), .illegal(i8)
  );

  leg_alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid & sel16), .in_ready(r16),
    .opcode(opcode), .in_a(in_a), .in_b(in_b),
    .out_valid(v16), .out_ready(out_ready), .result(res16),
    .zero(z16), .div0(d16), .illegal(i16)
  );

  assign vr   = sel16 ? r16 : r8;
  assign vv   = sel16 ? v16 : v8;
  assign vz   = sel16 ? z16 : z8;
  assign vd   = sel16 ? d16 : d8;
  assign vi   = sel16 ? i16 : i8;
  assign vres = sel16 ? res16 : {8'h00, res8};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Returns {illegal, div0, zero, result}.
  function automatic logic [18:0] model(input bit w16, input logic [3:0] op,
                                        input logic [15:0] a, input logic [15:0] b);
    int     w;
    longint m, av, bv, r;
    bit     ill, dz;
    w   = w16 ? 16 : 8;
    m   = (64'd1 << w) - 1;
    av  = longint'(a) & m;
    bv  = longint'(b) & m;
    ill = 1'b0;
    r   = 0;
    case (op)
      4'd0:  r = (av + bv) & m;
      4'd1:  r = (av - bv) & m;
      4'd2:  r = av & bv;
      4'd3:  r = av | bv;
      4'd4:  r = (~av) & m;
      4'd5:  r = av ^ bv;
      4'd8:  r = (av * bv) & m;
      4'd9:  r = (av * bv) >> w;
      4'd10: r = (bv == 0) ? m : av / bv;
      4'd11: r = (bv == 0) ? av : av % bv;
      default: begin ill = 1'b1; r = 0; end
    endcase
    dz = ((op == 4'd10) || (op == 4'd11)) && (bv == 0);
    return {ill, dz, (r == 0), r[15:0]};
  endfunction

  function automatic int model_lat(input bit w16, input logic [3:0] op);
    if (op >= 4'd8 && op <= 4'd11) return (w16 ? 16 : 8) + 1;
    return 1;
  endfunction

  bit          pend = 1'b0;
  bit          pseen;
  logic [18:0] pexp;
  int          pcyc, plat;

  always @(negedge clk) begin
    if (!rst) begin
      chk("reset_state", {11'd0, vr, vv, vz, vd, vi, vres}, {11'd0, 1'b1, 4'b0000, 16'h0000});
      pend = 1'b0;
    end else begin
      if (pend) chk("in_ready_low", {31'd0, vr}, 32'd0);
      if (vv) begin
        if (!pend) begin
          chk("spurious_valid", {31'd0, vv}, 32'd0);
        end else begin
          if (!pseen) begin
            chk("model_latency", cyc - pcyc, plat);
            pseen = 1'b1;
          end
          chk("model_out", {13'd0, vi, vd, vz, vres}, {13'd0, pexp});
          if (out_ready) pend = 1'b0;
        end
      end else if (pend && (cyc - pcyc > plat)) begin
        chk("model_timeout", {31'd0, vv}, 32'd1);
        pend = 1'b0;
      end
      if (in_valid && vr) begin
        pend  = 1'b1;
        pseen = 1'b0;
        pcyc  = cyc;
        pexp  = model(sel16, opcode[3:0], in_a, in_b);
        plat  = model_lat(sel16, opcode[3:0]);
      end
    end
  end

  // exp_flg is {illegal, div0, zero}.
  task automatic do_op(input bit w16, input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                       input bit lit, input logic [15:0] exp_res, input logic [2:0] exp_flg,
                       input int exp_lat, input int hold, input string nm);
    int t0, n;
    @(posedge clk); #1;
    sel16 = w16; opcode = op; in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
    t0 = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    opcode = 8'($urandom); in_a = 16'($urandom); in_b = 16'($urandom);
    n = 0;
    while (!vv && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!vv) begin
      chk({nm, "_timeout"}, {31'd0, vv}, 32'd1);
    end else if (lit) begin
      chk({nm, "_lat"}, cyc - t0, exp_lat);
      chk({nm, "_res"}, {16'd0, vres}, {16'd0, exp_res});
      chk({nm, "_flags"}, {29'd0, vi, vd, vz}, {29'd0, exp_flg});
    end
    repeat (hold) begin
      @(posedge clk); #1;
    end
    if (lit && hold > 0) chk({nm, "_hold"}, {16'd0, vres}, {16'd0, exp_res});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; sel16 = 1'b0; opcode = '0;
    in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // WIDTH=8 directed vectors
    do_op(0, 8'h00, 16'h00F0, 16'h0020, 1, 16'h0010, 3'b000, 1, 0, "add");
    do_op(0, 8'h01, 16'h0005, 16'h0005, 1, 16'h0000, 3'b001, 1, 5, "sub_zero");
    do_op(0, 8'h02, 16'h00CC, 16'h00AA, 1, 16'h0088, 3'b000, 1, 0, "and");
    do_op(0, 8'h03, 16'h00CC, 16'h00AA, 1, 16'h00EE, 3'b000, 1, 0, "or");
    do_op(0, 8'h04, 16'h000F, 16'h0055, 1, 16'h00F0, 3'b000, 1, 0, "not");
    do_op(0, 8'h05, 16'h00CC, 16'h00AA, 1, 16'h0066, 3'b000, 1, 0, "xor");
    do_op(0, 8'h08, 16'h00FF, 16'h00FF, 1, 16'h0001, 3'b000, 9, 2, "mul");
    do_op(0, 8'h09, 16'h00FF, 16'h00FF, 1, 16'h00FE, 3'b000, 9, 0, "mulh");
    do_op(0, 8'h0A, 16'h0064, 16'h0007, 1, 16'h000E, 3'b000, 9, 0, "div");
    do_op(0, 8'h0B, 16'h0064, 16'h0007, 1, 16'h0002, 3'b000, 9, 0, "mod");
    do_op(0, 8'h0A, 16'h002A, 16'h0000, 1, 16'h00FF, 3'b010, 9, 0, "div0");
    do_op(0, 8'h0B, 16'h002A, 16'h0000, 1, 16'h002A, 3'b010, 9, 0, "mod0");
    do_op(0, 8'h0A, 16'h0007, 16'h0064, 1, 16'h0000, 3'b001, 9, 0, "div_small");
    do_op(0, 8'h07, 16'h0012, 16'h0034, 1, 16'h0000, 3'b101, 1, 0, "illegal7");
    do_op(0, 8'h0C, 16'h0012, 16'h0034, 1, 16'h0000, 3'b101, 1, 0, "illegalC");
    do_op(0, 8'hF8, 16'h0003, 16'h0004, 1, 16'h000C, 3'b000, 9, 0, "mul_hiops");

    // Reset in the third BUSY cycle of a multiply
    @(posedge clk); #1;
    sel16 = 1'b0; opcode = 8'h08; in_a = 16'h0003; in_b = 16'h0005; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_mid_ready", {31'd0, vr}, 32'd1);
    chk("rst_mid_valid", {31'd0, vv}, 32'd0);
    chk("rst_mid_result", {16'd0, vres}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    do_op(0, 8'h08, 16'h0003, 16'h0004, 1, 16'h000C, 3'b000, 9, 0, "mul_after_rst");

    // WIDTH=16 directed vectors
    do_op(1, 8'h08, 16'hFFFF, 16'h0002, 1, 16'hFFFE, 3'b000, 17, 0, "mul16");
    do_op(1, 8'h09, 16'hFFFF, 16'h0002, 1, 16'h0001, 3'b000, 17, 0, "mulh16");
    do_op(1, 8'h0A, 16'hFFFF, 16'h0010, 1, 16'h0FFF, 3'b000, 17, 0, "div16");
    do_op(1, 8'h0B, 16'h1234, 16'h0100, 1, 16'h0034, 3'b000, 17, 0, "mod16");
    do_op(1, 8'h0A, 16'h1234, 16'h0000, 1, 16'hFFFF, 3'b010, 17, 0, "div0_16");
    do_op(1, 8'h00, 16'hFFFF, 16'h0001, 1, 16'h0000, 3'b001, 1, 0, "add16_wrap");

    // Random ops checked by the model only
    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra, rb;
      bit          w;
      w  = (i % 2 == 0);
      ra = 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      do_op(w, 8'($urandom), ra, rb, 0, 16'h0000, 3'b000, 0, $urandom_range(0, 3), "rnd");
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
